id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage of the RV32I core. It registers one decoded instruction and applies operand forwarding from the EX/MEM and MEM/WB stages. It selects the PC/immediate operand muxes and drives ALUop1, ALUop2 and ALUCtrl into the ALU directly downstream. It also detects load-use hazards, inserts bubbles, and exposes a saturating bubble counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of operands, PC, immediate and forwarded results
ALUCTRL_WIDTH, 4, ALU opcode width {funct7[5], funct3}, passed through undecoded
REG_ADDR_WIDTH, 5, register address width
CNT_WIDTH, 16, width of bubble_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  decode holds a valid instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  DATA_WIDTH  instruction PC
in_rs1_data  in  DATA_WIDTH  register file read port 1
in_rs2_data  in  DATA_WIDTH  register file read port 2
in_imm  in  DATA_WIDTH  sign-extended immediate
in_rs1_addr, in_rs2_addr, in_rd_addr  in  REG_ADDR_WIDTH each  source/dest registers
in_alu_ctrl  in  ALUCTRL_WIDTH  ALU opcode
in_ctrl  in  5  {src_a_pc, src_b_imm, reg_write, mem_read, mem_write}
flush  in  1  branch/jump redirect; kill held instruction
exm_rd  in  REG_ADDR_WIDTH  EX/MEM destination
exm_ctrl  in  2  {reg_write, mem_read} of EX/MEM
exm_result  in  DATA_WIDTH  EX/MEM ALU result
wb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes register
wb_result  in  DATA_WIDTH  MEM/WB writeback value
out_valid  out  1  ALU inputs valid
out_ready  in  1  downstream accepts
ALUCtrl  out  ALUCTRL_WIDTH  to ALU
ALUop1, ALUop2  out  DATA_WIDTH each  to ALU
out_store_data  out  DATA_WIDTH  forwarded rs2 for stores
out_pc  out  DATA_WIDTH  registered PC
out_rd  out  REG_ADDR_WIDTH  registered rd
out_ctrl  out  3  {reg_write, mem_read, mem_write}
bubble_count  out  CNT_WIDTH  load-use bubbles inserted, saturating

Behaviour:
- State: valid bit V plus payload registers for every in_* field.
- Reset (async, immediate): V=0, payload=0, bubble_count=0. Outputs: out_valid=0, in_ready=1, ALUCtrl=0, ALUop1=ALUop2=out_store_data=0, out_pc=0, out_rd=0, out_ctrl=0.
- Operand use: rs1_used = !src_a_pc. rs2_used = !src_b_imm | mem_write.
- hazard = V & exm_reg_write & exm_mem_read & exm_rd!=0 & ((rs1_used & exm_rd==rs1) | (rs2_used & exm_rd==rs2)).
- Handshake:
  - out_valid = V & !hazard.
  - in_ready = !V | (out_valid & out_ready).
  - accept = in_valid & in_ready.
  - xfer = out_valid & out_ready.
- Next V:
  - flush -> 0. Flush has priority over accept; an instruction accepted in the same cycle is discarded.
  - else accept -> 1.
  - else xfer -> 0.
  - else hold.
- Forwarding (combinational, per source rs):
  - If exm_reg_write & !exm_mem_read & exm_rd!=0 & exm_rd==rs, use exm_result.
  - Else if wb_reg_write & wb_rd!=0 & wb_rd==rs, use wb_result.
  - Else use the stored data.
  - EX/MEM takes priority over WB. rs=0 never forwards.
- Capture on accept: rs data is loaded with WB bypass applied (wb_result if wb_reg_write & wb_rd!=0 & wb_rd==in_rs). This covers same-cycle register file writes.
- Refresh on hold: every cycle with V=1 and no accept, the stored rs1/rs2 data are overwritten with the forwarded values. Stalled operands therefore never go stale when producers retire.
- Output muxing:
  - ALUop1 = src_a_pc ? pc : fwd1.
  - ALUop2 = src_b_imm ? imm : fwd2.
  - out_store_data = fwd2.
  - ALUCtrl, out_pc, out_rd, out_ctrl come from registers.
  - Payload outputs are don't-care when out_valid=0; the bench checks them only when out_valid=1.
- Latency: one cycle from accept to out_valid when there is no hazard. A load-use hazard adds exactly one bubble.
- bubble_count: increments each cycle hazard=1. Holds at all-ones. Flush does not clear it.

Test Plan:
- Reset mid-stream with V=1 -> next edge out_valid=0, in_ready=1, bubble_count=0, ALUop1/ALUop2=0.
- ADDI x5,x1,7 (in_rs1_data=10, imm=7, ALUCtrl=0000), out_ready=1 -> next cycle out_valid=1, ALUop1=10, ALUop2=7, in_ready=1.
- ADD x3,x1,x2 with exm_rd=1/exm_result=0x100 and wb_rd=2/wb_result=0x20 -> ALUop1=0x100, ALUop2=0x20. With exm_rd=wb_rd=1, EX/MEM wins (0x100).
- LW x4 in EX/MEM (exm_ctrl=11, exm_rd=4) followed by SUB x6,x4,x1 -> one cycle out_valid=0, in_ready=0, bubble_count=1. Next cycle wb_rd=4/wb_result=0xDEAD gives ALUop1=0xDEAD, out_valid=1.
- Hold with out_ready=0 for 3 cycles while wb forwards x2=0x55 only in cycle 1 -> released operand ALUop2=0x55, not the stale register file value.
- flush asserted with in_valid=1, V=1 -> next cycle out_valid=0. Instruction offered in the flush cycle never appears at the outputs.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the RV32I core: holds one decoded instruction,
// forwards operands from EX/MEM and MEM/WB, stalls on load-use hazards and counts bubbles.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUCTRL_WIDTH  = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [ALUCTRL_WIDTH-1:0]  in_alu_ctrl,
  input  logic [4:0]                in_ctrl,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic [1:0]                exm_ctrl,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ALUCTRL_WIDTH-1:0]  ALUCtrl,
  output logic [DATA_WIDTH-1:0]     ALUop1,
  output logic [DATA_WIDTH-1:0]     ALUop2,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [2:0]                out_ctrl,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  logic                      v_q, v_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [ALUCTRL_WIDTH-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic [4:0]                ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]      bubble_q, bubble_d;

  logic src_a_pc, src_b_imm, mem_write, rs1_used, rs2_used;
  logic exm_rw, exm_mr, hazard, accept, xfer;
  logic [DATA_WIDTH-1:0] fwd1, fwd2, cap1, cap2;

  assign src_a_pc  = ctrl_q[4];
  assign src_b_imm = ctrl_q[3];
  assign mem_write = ctrl_q[0];
  assign rs1_used  = !src_a_pc;
  assign rs2_used  = !src_b_imm || mem_write;
  assign exm_rw    = exm_ctrl[1];
  assign exm_mr    = exm_ctrl[0];

  assign hazard = v_q && exm_rw && exm_mr && (exm_rd != '0) &&
                  ((rs1_used && (exm_rd == rs1_q)) || (rs2_used && (exm_rd == rs2_q)));

  assign out_valid = v_q && !hazard;
  assign xfer      = out_valid && out_ready;
  assign in_ready  = !v_v_q_n() ;
  function automatic logic v_v_q_n();
    return v_q && !xfer;
  endfunction
  assign accept    = in_valid && in_ready;

  // EX/MEM wins over WB; a load result in EX/MEM is not available yet and never forwards.
  always_comb begin
    fwd1 = rs1_data_q;
    if (exm_rw && !exm_mr && (exm_rd != '0) && (exm_rd == rs1_q))
      fwd1 = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q))
      fwd1 = wb_result;

    fwd2 = rs2_data_q;
    if (exm_rw && !exm_mr && (exm_rd != '0) && (exm_rd == rs2_q))
      fwd2 = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q))
      fwd2 = wb_result;
  end

  // The register file write lands at the same edge we capture, so bypass WB on the way in.
  always_comb begin
    cap1 = in_rs1_data;
    cap2 = in_rs2_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == in_rs1_addr)) cap1 = wb_result;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == in_rs2_addr)) cap2 = wb_result;
  end

  always_comb begin
    v_d        = v_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alu_ctrl_d = alu_ctrl_q;
    ctrl_d     = ctrl_q;
    bubble_d   = bubble_q;

    if (flush)       v_d = 1'b0;
    else if (accept) v_d = 1'b1;
    else if (xfer)   v_d = 1'b0;

    if (accept) begin
      pc_d       = in_pc;
      rs1_data_d = cap1;
      rs2_data_d = cap2;
      imm_d      = in_imm;
      rs1_d      = in_rs1_addr;
      rs2_d      = in_rs2_addr;
      rd_d       = in_rd_addr;
      alu_ctrl_d = in_alu_ctrl;
      ctrl_d     = in_ctrl;
    end else if (v_q) begin
      // Keep stalled operands current as producers retire out of the forwarding window.
      rs1_data_d = fwd1;
      rs2_data_d = fwd2;
    end

    if (hazard && (bubble_q != '1))
      bubble_d = bubble_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_ctrl_q <= '0;
      ctrl_q     <= '0;
      bubble_q   <= '0;
    end else begin
      v_q        <= v_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_ctrl_q <= alu_ctrl_d;
      ctrl_q     <= ctrl_d;
      bubble_q   <= bubble_d;
    end
  end

  assign ALUop1         = src_a_pc ? pc_q : fwd1;
  assign ALUop2         = src_b_imm ? imm_q : fwd2;
  assign out_store_data = fwd2;
  assign ALUCtrl        = alu_ctrl_q;
  assign out_pc         = pc_q;
  assign out_rd         = rd_q;
  assign out_ctrl       = ctrl_q[2:0];
  assign bubble_count   = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-instruction vectors with hand-computed
// operands, followed by hand-written stall, hold, flush, saturation and reset sequences.
module tb_id_ex_stage;

  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, wb_reg_write, out_valid, out_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm, exm_result, wb_result;
  logic [31:0] ALUop1, ALUop2, out_store_data, out_pc;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, exm_rd, wb_rd, out_rd, in_ctrl;
  logic [3:0]  in_alu_ctrl, ALUCtrl;
  logic [1:0]  exm_ctrl;
  logic [2:0]  out_ctrl;
  logic [CW-1:0] bubble_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [4:0]  ctrl;
    logic [4:0]  exmRd;
    logic [1:0]  exmCtrl;
    logic [31:0] exmRes;
    logic [4:0]  wbRd;
    logic        wbRw;
    logic [31:0] wbRes;
    logic [31:0] expOp1, expOp2, expStore;
  } vec_t;

  vec_t vecs[9];
  vec_t v;

  id_ex_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_ctrl(in_alu_ctrl), .in_ctrl(in_ctrl), .flush(flush),
    .exm_rd(exm_rd), .exm_ctrl(exm_ctrl), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready), .ALUCtrl(ALUCtrl),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .out_store_data(out_store_data),
    .out_pc(out_pc), .out_rd(out_rd), .out_ctrl(out_ctrl), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    in_pc        = s.pc;
    in_rs1_data  = s.rs1d;
    in_rs2_data  = s.rs2d;
    in_imm       = s.imm;
    in_rs1_addr  = s.rs1;
    in_rs2_addr  = s.rs2;
    in_rd_addr   = s.rd;
    in_alu_ctrl  = s.alu;
    in_ctrl      = s.ctrl;
    exm_rd       = s.exmRd;
    exm_ctrl     = s.exmCtrl;
    exm_result   = s.exmRes;
    wb_rd        = s.wbRd;
    wb_reg_write = s.wbRw;
    wb_result    = s.wbRes;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pc, rs1d, rs2d, imm, rs1, rs2, rd, alu, ctrl{a_pc,b_imm,rw,mr,mw}, exmRd, exmCtrl, exmRes, wbRd, wbRw, wbRes, op1, op2, store
    vecs[0] = '{32'h100, 32'd10, 32'h33, 32'd7, 5'd1, 5'd0, 5'd5, 4'b0000, 5'b01100, 5'd0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0, 32'd10, 32'd7, 32'h33};
    vecs[1] = '{32'h104, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0000, 5'b00100, 5'd1, 2'b10, 32'h100, 5'd2, 1'b1, 32'h20, 32'h100, 32'h20, 32'h20};
    vecs[2] = '{32'h108, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0000, 5'b00100, 5'd1, 2'b10, 32'h100, 5'd1, 1'b1, 32'h20, 32'h100, 32'd2, 32'd2};
    vecs[3] = '{32'h10C, 32'd1, 32'd9, 32'd0, 5'd1, 5'd2, 5'd6, 4'b1000, 5'b00100, 5'd0, 2'b00, 32'h0, 5'd1, 1'b1, 32'h77, 32'h77, 32'd9, 32'd9};
    vecs[4] = '{32'h110, 32'h11, 32'h22, 32'd0, 5'd0, 5'd0, 5'd7, 4'b0000, 5'b00100, 5'd0, 2'b10, 32'hBAD, 5'd0, 1'b1, 32'hBEEF, 32'h11, 32'h22, 32'h22};
    vecs[5] = '{32'h1000, 32'd3, 32'd4, 32'h5000, 5'd1, 5'd2, 5'd8, 4'b0000, 5'b11100, 5'd1, 2'b10, 32'h100, 5'd2, 1'b1, 32'h20, 32'h1000, 32'h5000, 32'h20};
    vecs[6] = '{32'h114, 32'h200, 32'h44, 32'd8, 5'd1, 5'd2, 5'd0, 4'b0010, 5'b01001, 5'd2, 2'b10, 32'h99, 5'd0, 1'b0, 32'h0, 32'h200, 32'd8, 32'h99};
    vecs[7] = '{32'h118, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd9, 4'b0111, 5'b00100, 5'd7, 2'b11, 32'hAAA, 5'd7, 1'b1, 32'hBBB, 32'd5, 32'd6, 32'd6};
    vecs[8] = '{32'h11C, 32'h30, 32'h40, 32'hFFFFFFFC, 5'd1, 5'd4, 5'd5, 4'b0000, 5'b01100, 5'd4, 2'b11, 32'hCCC, 5'd0, 1'b0, 32'h0, 32'h30, 32'hFFFFFFFC, 32'h40};

    v = '{32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 5'd0, 5'd0, 2'd0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    tick(); tick();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_bubble", {29'd0, bubble_count}, 32'd0);
    checkOutput("rst_op1", ALUop1, 32'd0);
    checkOutput("rst_op2", ALUop2, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checkOutput($sformatf("v%0d_pre_out_valid", i), {31'd0, out_valid}, 32'd0);
      tick();
      in_valid = 1'b0;
      #1;
      checkOutput($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      checkOutput($sformatf("v%0d_op1", i), ALUop1, vecs[i].expOp1);
      checkOutput($sformatf("v%0d_op2", i), ALUop2, vecs[i].expOp2);
      checkOutput($sformatf("v%0d_store", i), out_store_data, vecs[i].expStore);
      checkOutput($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      checkOutput($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      checkOutput($sformatf("v%0d_ctrl", i), {29'd0, out_ctrl}, {29'd0, vecs[i].ctrl[2:0]});
      checkOutput($sformatf("v%0d_aluctrl", i), {28'd0, ALUCtrl}, {28'd0, vecs[i].alu});
      tick();
      checkOutput($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // WB bypass at capture: the write retires at the accept edge, stale regfile value must not leak.
    v = '{32'h120, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0000, 5'b00100, 5'd0, 2'b00, 32'h0, 5'd1, 1'b1, 32'h66, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; wb_reg_write = 1'b0;
    #1;
    checkOutput("cap_bypass_op1", ALUop1, 32'h66);
    checkOutput("cap_bypass_op2", ALUop2, 32'h2);
    tick();

    // Load-use: LW x4 in EX/MEM then SUB x6,x4,x1.
    v = '{32'h200, 32'h1111, 32'd5, 32'd0, 5'd4, 5'd1, 5'd6, 4'b1000, 5'b00100, 5'd4, 2'b11, 32'hEEE, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput("lu_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    exm_ctrl = 2'b00; exm_rd = 5'd0; wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'hDEAD;
    #1;
    checkOutput("lu_bubble", {29'd0, bubble_count}, 32'd1);
    checkOutput("lu_out_valid_after", {31'd0, out_valid}, 32'd1);
    checkOutput("lu_op1", ALUop1, 32'hDEAD);
    checkOutput("lu_op2", ALUop2, 32'd5);
    tick();
    wb_reg_write = 1'b0;

    // Hold three cycles; x2 is forwarded from WB only in the first held cycle.
    v = '{32'h300, 32'h1, 32'h10, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0000, 5'b00100, 5'd0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; wb_rd = 5'd2; wb_reg_write = 1'b1; wb_result = 32'h55;
    #1;
    checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    wb_reg_write = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    #1;
    checkOutput("hold_op2", ALUop2, 32'h55);
    checkOutput("hold_store", out_store_data, 32'h55);
    checkOutput("hold_op1", ALUop1, 32'h1);
    tick();
    checkOutput("hold_drained", {31'd0, out_valid}, 32'd0);

    // Long load-use stall drives the narrow counter into saturation.
    v = '{32'h400, 32'h1111, 32'd5, 32'd0, 5'd4, 5'd1, 5'd6, 4'b1000, 5'b00100, 5'd4, 2'b11, 32'hEEE, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checkOutput("sat_bubble", {29'd0, bubble_count}, 32'd7);
    checkOutput("sat_out_valid", {31'd0, out_valid}, 32'd0);
    exm_ctrl = 2'b00; wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'hDEAD;
    #1;
    checkOutput("sat_release_op1", ALUop1, 32'hDEAD);
    tick();
    wb_reg_write = 1'b0;

    // Flush while holding A and offering B in the same cycle.
    v = '{32'hA0, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd10, 4'b0000, 5'b00100, 5'd0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    v.pc = 32'hB0; v.rd = 5'd11;
    applyStimulus(v);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_bubble_kept", {29'd0, bubble_count}, 32'd7);
    tick();
    checkOutput("flush_out_valid_later", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with a valid instruction held.
    v = '{32'h500, 32'h9, 32'h8, 32'h7, 5'd1, 5'd2, 5'd3, 4'b0101, 5'b11100, 5'd1, 2'b10, 32'h123, 5'd2, 1'b1, 32'h456, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput("pre_rst_op1", ALUop1, 32'h500);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_op1", ALUop1, 32'd0);
    tick();
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_bubble", {29'd0, bubble_count}, 32'd0);
    checkOutput("mid_rst_op2", ALUop2, 32'd0);
    checkOutput("mid_rst_pc", out_pc, 32'd0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
